// File: rtl/flux_band_scheduler_pkg.sv
// Shared types for the flux band scheduler: band ids, FSM states and the
// saturating increment used by the event counters.
package bpm_pkg;

  typedef enum logic [1:0] {
    BAND_LOW  = 2'd0,
    BAND_MID  = 2'd1,
    BAND_HIGH = 2'd2
  } band_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_RES,
    ST_COMBINE
  } state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/flux_band_scheduler_if.sv
// Request/result handshake between the scheduler (master) and the shared
// autocorrelation engine (slave).
interface flux_band_scheduler_if #(
  parameter int FW = 74,
  parameter int BW = 16
) ();

  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_band;
  logic [FW-1:0] req_flux;
  logic          res_valid;
  logic [1:0]    res_band;
  logic [BW-1:0] res_bpm;

  modport master (
    output req_valid, req_band, req_flux,
    input  req_ready, res_valid, res_band, res_bpm
  );

  modport slave (
    input  req_valid, req_band, req_flux,
    output req_ready, res_valid, res_band, res_bpm
  );

endinterface

// File: rtl/flux_band_scheduler_sat_counter.sv
// 16-bit event counter that sticks at 0xFFFF instead of wrapping.
module sat_counter
  import bpm_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        inc,
  output logic [15:0] count
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (inc) begin
      count <= sat_inc16(count);
    end
  end

endmodule

// File: rtl/flux_band_scheduler.sv
// Shares one autocorrelation engine across the low/mid/high flux bands and
// folds the three per-band BPM results into one weighted estimate.
module flux_band_scheduler
  import bpm_pkg::*;
#(
  parameter int FW      = 74,
  parameter int BW      = 16,
  parameter int WL      = 2,
  parameter int WM      = 1,
  parameter int WH      = 1,
  parameter int WSHIFT  = 2,
  parameter int TIMEOUT = 65535
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flux_valid,
  input  logic [FW-1:0]         flux_low,
  input  logic [FW-1:0]         flux_mid,
  input  logic [FW-1:0]         flux_high,
  flux_band_scheduler_if.master eng,
  output logic [BW-1:0]         bpm_low,
  output logic [BW-1:0]         bpm_mid,
  output logic [BW-1:0]         bpm_high,
  output logic [BW-1:0]         final_bpm,
  output logic                  bpm_valid,
  output logic                  busy,
  output logic [15:0]           overrun_cnt,
  output logic [15:0]           timeout_cnt,
  output logic                  band_err
);

  localparam int SW = BW + WSHIFT + 2;
  // The wait counter only needs to reach TIMEOUT-1, the cycle the timeout fires.
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  if ((WL + WM + WH) != (2 ** WSHIFT)) begin : g_weight_check
    $error("flux_band_scheduler: WL+WM+WH must equal 2**WSHIFT");
  end

  state_t        state, state_n;
  band_t         band, band_n;
  logic [FW-1:0] held_low, held_mid, held_high;
  logic [TW-1:0] wait_cnt;
  logic          res_hit;
  logic          timed_out;
  logic          overrun_inc;
  logic [SW-1:0] weighted_sum;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      band  <= BAND_LOW;
    end else begin
      state <= state_n;
      band  <= band_n;
    end
  end

  always_comb begin
    state_n       = state;
    band_n        = band;
    eng.req_valid = 1'b0;
    res_hit       = 1'b0;
    timed_out     = 1'b0;
    band_err      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (flux_valid) begin
          state_n = ST_ISSUE;
          band_n  = BAND_LOW;
        end
      end
      ST_ISSUE: begin
        eng.req_valid = 1'b1;
        if (eng.req_ready) state_n = ST_WAIT_RES;
      end
      ST_WAIT_RES: begin
        // A result arriving in the timeout cycle wins over the timeout.
        if (eng.res_valid && (eng.res_band == band)) begin
          res_hit = 1'b1;
        end else begin
          band_err  = eng.res_valid;
          timed_out = (wait_cnt == TW'(TIMEOUT - 1));
        end
        if (res_hit || timed_out) begin
          if (band == BAND_HIGH) begin
            state_n = ST_COMBINE;
          end else begin
            band_n  = band_t'(band + 2'd1);
            state_n = ST_ISSUE;
          end
        end
      end
      ST_COMBINE: state_n = ST_IDLE;
      default:    state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    eng.req_flux = '0;
    if (state == ST_ISSUE) begin
      case (band)
        BAND_LOW: eng.req_flux = held_low;
        BAND_MID: eng.req_flux = held_mid;
        default:  eng.req_flux = held_high;
      endcase
    end
  end

  assign eng.req_band = band;
  assign busy         = (state != ST_IDLE);
  assign overrun_inc  = flux_valid && (state != ST_IDLE);

  assign weighted_sum = SW'(WL) * SW'(bpm_low)
                      + SW'(WM) * SW'(bpm_mid)
                      + SW'(WH) * SW'(bpm_high);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      held_low  <= '0;
      held_mid  <= '0;
      held_high <= '0;
      wait_cnt  <= '0;
      bpm_low   <= '0;
      bpm_mid   <= '0;
      bpm_high  <= '0;
      final_bpm <= '0;
      bpm_valid <= 1'b0;
    end else begin
      if ((state == ST_IDLE) && flux_valid) begin
        held_low  <= flux_low;
        held_mid  <= flux_mid;
        held_high <= flux_high;
      end
      if ((state == ST_ISSUE) && eng.req_ready) begin
        wait_cnt <= '0;
      end else if (state == ST_WAIT_RES) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (res_hit) begin
        case (band)
          BAND_LOW: bpm_low  <= eng.res_bpm;
          BAND_MID: bpm_mid  <= eng.res_bpm;
          default:  bpm_high <= eng.res_bpm;
        endcase
      end
      if (state == ST_COMBINE) begin
        final_bpm <= BW'(weighted_sum >> WSHIFT);
      end
      bpm_valid <= (state == ST_COMBINE);
    end
  end

  sat_counter u_overrun_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (overrun_inc),
    .count   (overrun_cnt)
  );

  sat_counter u_timeout_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (timed_out),
    .count   (timeout_cnt)
  );

endmodule

// File: tb/tb_flux_band_scheduler.sv
// Directed bench for flux_band_scheduler: table of single frames plus
// hand-written backpressure, timeout, overrun, band error and reset sequences.
module tb_flux_band_scheduler;

  localparam int FW = 74;
  localparam int BW = 16;

  typedef struct {
    logic [FW-1:0] fl;
    logic [FW-1:0] fm;
    logic [FW-1:0] fh;
    logic [BW-1:0] rl;
    logic [BW-1:0] rm;
    logic [BW-1:0] rh;
    logic [BW-1:0] exp_final;
  } vec_t;

  logic          clk;
  logic          reset_n;
  logic          flux_valid;
  logic [FW-1:0] flux_low, flux_mid, flux_high;
  logic [BW-1:0] bpm_low, bpm_mid, bpm_high, final_bpm;
  logic          bpm_valid, busy, band_err;
  logic [15:0]   overrun_cnt, timeout_cnt;

  int checks;
  int errors;

  // Engine model configuration (written by the main sequence only).
  logic          eng_on;
  int            eng_lat;
  logic [BW-1:0] eng_res [4];
  logic [2:0]    eng_skip;
  logic          eng_bad;
  // Engine model observations (written by the engine process only).
  int            hs_count;
  logic [FW-1:0] cap_flux [4];

  vec_t vecs [6];

  flux_band_scheduler_if #(.FW(FW), .BW(BW)) bus ();

  flux_band_scheduler #(
    .FW(FW), .BW(BW), .WL(2), .WM(1), .WH(1), .WSHIFT(2), .TIMEOUT(16)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .flux_valid  (flux_valid),
    .flux_low    (flux_low),
    .flux_mid    (flux_mid),
    .flux_high   (flux_high),
    .eng         (bus.master),
    .bpm_low     (bpm_low),
    .bpm_mid     (bpm_mid),
    .bpm_high    (bpm_high),
    .final_bpm   (final_bpm),
    .bpm_valid   (bpm_valid),
    .busy        (busy),
    .overrun_cnt (overrun_cnt),
    .timeout_cnt (timeout_cnt),
    .band_err    (band_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Engine: answers a request accepted in cycle h with res_valid in cycle h+eng_lat+1.
  initial begin : engine
    int d_good;
    int d_bad;
    logic [1:0] pb;
    bus.res_valid = 1'b0;
    bus.res_band  = 2'd0;
    bus.res_bpm   = '0;
    hs_count      = 0;
    d_good        = 0;
    d_bad         = 0;
    pb            = 2'd0;
    for (int i = 0; i < 4; i++) cap_flux[i] = '0;
    forever begin
      @(negedge clk);
      #1;
      bus.res_valid = 1'b0;
      bus.res_band  = 2'd0;
      bus.res_bpm   = '0;
      if (d_bad > 0) begin
        d_bad--;
        if (d_bad == 0) begin
          bus.res_valid = 1'b1;
          bus.res_band  = 2'd2;
          bus.res_bpm   = 16'd999;
        end
      end
      if (d_good > 0) begin
        d_good--;
        if (d_good == 0) begin
          bus.res_valid = 1'b1;
          bus.res_band  = pb;
          bus.res_bpm   = eng_res[pb];
        end
      end
      if (bus.req_valid && bus.req_ready) begin
        hs_count++;
        pb           = bus.req_band;
        cap_flux[pb] = bus.req_flux;
        if (eng_on && !eng_skip[pb]) d_good = eng_lat + 1;
        if (eng_bad && (pb == 2'd0)) d_bad = 2;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [127:0] act,
                             input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic setEngine(input logic [BW-1:0] rl, input logic [BW-1:0] rm,
                           input logic [BW-1:0] rh);
    eng_res[0] = rl;
    eng_res[1] = rm;
    eng_res[2] = rh;
    eng_res[3] = '0;
  endtask

  // Drives one frame at k=0 and optional extra flux pulses at k=ov1/ov2, then
  // waits (bounded) for bpm_valid; lat=-1 means it never came.
  task automatic applyStimulus(input logic [FW-1:0] fl, input logic [FW-1:0] fm,
                               input logic [FW-1:0] fh, input int ov1, input int ov2,
                               input int budget, output int lat, output int err_cnt,
                               output int err_k, output logic [BW-1:0] hi_after,
                               output logic wait_after);
    lat        = -1;
    err_cnt    = 0;
    err_k      = -1;
    hi_after   = '0;
    wait_after = 1'b0;
    @(negedge clk);
    flux_valid = 1'b1;
    flux_low   = fl;
    flux_mid   = fm;
    flux_high  = fh;
    #2;
    for (int k = 1; k <= budget && lat < 0; k++) begin
      @(negedge clk);
      if (k == ov1 || k == ov2) begin
        flux_valid = 1'b1;
        flux_low   = {FW{1'b1}};
        flux_mid   = {FW{1'b1}};
        flux_high  = {FW{1'b1}};
      end else begin
        flux_valid = 1'b0;
        flux_low   = '0;
        flux_mid   = '0;
        flux_high  = '0;
      end
      #2;
      if (err_k >= 0 && k == err_k + 1) begin
        hi_after   = bpm_high;
        wait_after = busy && !bus.req_valid;
      end
      if (band_err) begin
        err_cnt++;
        if (err_k < 0) err_k = k;
      end
      if (bpm_valid) lat = k;
    end
    flux_valid = 1'b0;
  endtask

  initial begin : main
    int lat, err_cnt, err_k, hs0;
    logic [BW-1:0] hi_after;
    logic wait_after;

    checks        = 0;
    errors        = 0;
    reset_n       = 1'b0;
    flux_valid    = 1'b0;
    flux_low      = '0;
    flux_mid      = '0;
    flux_high     = '0;
    bus.req_ready = 1'b1;
    eng_on        = 1'b1;
    eng_lat       = 4;
    eng_skip      = 3'b000;
    eng_bad       = 1'b0;
    setEngine(16'd0, 16'd0, 16'd0);

    vecs[0] = '{fl: 74'h1_2345_6789_ABCD_EF01, fm: 74'h2_0000_0000_0000_0002,
                fh: 74'h3_FFFF_FFFF_FFFF_FFFF, rl: 16'd120, rm: 16'd100, rh: 16'd140,
                exp_final: 16'd120};
    vecs[1] = '{fl: 74'h0, fm: 74'h0, fh: 74'h0, rl: 16'd0, rm: 16'd0, rh: 16'd0,
                exp_final: 16'd0};
    vecs[2] = '{fl: 74'h2_AAAA_AAAA_AAAA_AAAA, fm: 74'h1_5555_5555_5555_5555,
                fh: 74'h0_0000_0000_0000_00FF, rl: 16'hFFFF, rm: 16'hFFFF, rh: 16'hFFFF,
                exp_final: 16'hFFFF};
    vecs[3] = '{fl: 74'h1, fm: 74'h2, fh: 74'h3, rl: 16'd1, rm: 16'd2, rh: 16'd3,
                exp_final: 16'd1};
    vecs[4] = '{fl: 74'hDEAD_BEEF, fm: 74'hCAFE_F00D, fh: 74'h3_0000_0000_0000_0000,
                rl: 16'd1000, rm: 16'd3000, rh: 16'd7, exp_final: 16'd1251};
    vecs[5] = '{fl: 74'h0_1111_2222_3333_4444, fm: 74'h0_5555_6666_7777_8888,
                fh: 74'h0_9999_AAAA_BBBB_CCCC, rl: 16'hFFFF, rm: 16'd0, rh: 16'd1,
                exp_final: 16'd32767};

    // Reset state
    repeat (3) @(negedge clk);
    #2;
    checkOutput("rst_busy_in_reset", 128'(busy), 128'(0));
    checkOutput("rst_reqv_in_reset", 128'(bus.req_valid), 128'(0));
    @(negedge clk);
    reset_n = 1'b1;
    #2;
    checkOutput("rst_req_valid", 128'(bus.req_valid), 128'(0));
    checkOutput("rst_req_band", 128'(bus.req_band), 128'(0));
    checkOutput("rst_req_flux", 128'(bus.req_flux), 128'(0));
    checkOutput("rst_bpm_low", 128'(bpm_low), 128'(0));
    checkOutput("rst_bpm_mid", 128'(bpm_mid), 128'(0));
    checkOutput("rst_bpm_high", 128'(bpm_high), 128'(0));
    checkOutput("rst_final", 128'(final_bpm), 128'(0));
    checkOutput("rst_bpm_valid", 128'(bpm_valid), 128'(0));
    checkOutput("rst_busy", 128'(busy), 128'(0));
    checkOutput("rst_band_err", 128'(band_err), 128'(0));
    checkOutput("rst_overrun", 128'(overrun_cnt), 128'(0));
    checkOutput("rst_timeout", 128'(timeout_cnt), 128'(0));

    // Table of single frames, engine latency 4, req_ready tied high
    for (int i = 0; i < 6; i++) begin
      setEngine(vecs[i].rl, vecs[i].rm, vecs[i].rh);
      applyStimulus(vecs[i].fl, vecs[i].fm, vecs[i].fh, -1, -1, 60,
                    lat, err_cnt, err_k, hi_after, wait_after);
      checkOutput($sformatf("row%0d_latency", i), 128'(lat), 128'(20));
      checkOutput($sformatf("row%0d_bpm_low", i), 128'(bpm_low), 128'(vecs[i].rl));
      checkOutput($sformatf("row%0d_bpm_mid", i), 128'(bpm_mid), 128'(vecs[i].rm));
      checkOutput($sformatf("row%0d_bpm_high", i), 128'(bpm_high), 128'(vecs[i].rh));
      checkOutput($sformatf("row%0d_final", i), 128'(final_bpm), 128'(vecs[i].exp_final));
      checkOutput($sformatf("row%0d_req_flux0", i), 128'(cap_flux[0]), 128'(vecs[i].fl));
      checkOutput($sformatf("row%0d_req_flux1", i), 128'(cap_flux[1]), 128'(vecs[i].fm));
      checkOutput($sformatf("row%0d_req_flux2", i), 128'(cap_flux[2]), 128'(vecs[i].fh));
      checkOutput($sformatf("row%0d_band_err", i), 128'(err_cnt), 128'(0));
    end

    // Backpressure: req_ready low for 10 ISSUE cycles
    setEngine(16'd120, 16'd100, 16'd140);
    bus.req_ready = 1'b0;
    @(negedge clk);
    hs0        = hs_count;
    flux_valid = 1'b1;
    flux_low   = vecs[0].fl;
    flux_mid   = vecs[0].fm;
    flux_high  = vecs[0].fh;
    #2;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      flux_valid = 1'b0;
      #2;
      checkOutput($sformatf("bp_req_valid_k%0d", k), 128'(bus.req_valid), 128'(1));
      checkOutput($sformatf("bp_req_band_k%0d", k), 128'(bus.req_band), 128'(0));
      checkOutput($sformatf("bp_req_flux_k%0d", k), 128'(bus.req_flux), 128'(vecs[0].fl));
    end
    checkOutput("bp_no_accept_while_low", 128'(hs_count), 128'(hs0));
    @(negedge clk);
    bus.req_ready = 1'b1;
    lat = -1;
    for (int k = 12; k <= 80 && lat < 0; k++) begin
      @(negedge clk);
      #2;
      if (bpm_valid) lat = k;
    end
    checkOutput("bp_latency", 128'(lat), 128'(30));
    checkOutput("bp_handshakes", 128'(hs_count), 128'(hs0 + 3));
    checkOutput("bp_final", 128'(final_bpm), 128'(120));
    checkOutput("bp_bpm_mid", 128'(bpm_mid), 128'(100));

    // Timeout on band 1: bpm_mid keeps 100, band 2 still issued
    setEngine(16'd80, 16'd555, 16'd60);
    eng_skip = 3'b010;
    hs0 = hs_count;
    applyStimulus(vecs[3].fl, vecs[3].fm, vecs[3].fh, -1, -1, 80,
                  lat, err_cnt, err_k, hi_after, wait_after);
    eng_skip = 3'b000;
    checkOutput("to_latency", 128'(lat), 128'(31));
    checkOutput("to_timeout_cnt", 128'(timeout_cnt), 128'(1));
    checkOutput("to_bpm_low", 128'(bpm_low), 128'(80));
    checkOutput("to_bpm_mid_kept", 128'(bpm_mid), 128'(100));
    checkOutput("to_bpm_high", 128'(bpm_high), 128'(60));
    checkOutput("to_final", 128'(final_bpm), 128'(80));
    checkOutput("to_handshakes", 128'(hs_count), 128'(hs0 + 3));

    // Results landing exactly in the timeout cycle win
    setEngine(16'd200, 16'd204, 16'd208);
    eng_lat = 15;
    applyStimulus(vecs[4].fl, vecs[4].fm, vecs[4].fh, -1, -1, 100,
                  lat, err_cnt, err_k, hi_after, wait_after);
    eng_lat = 4;
    checkOutput("edge_latency", 128'(lat), 128'(53));
    checkOutput("edge_timeout_cnt", 128'(timeout_cnt), 128'(1));
    checkOutput("edge_bpm_low", 128'(bpm_low), 128'(200));
    checkOutput("edge_bpm_mid", 128'(bpm_mid), 128'(204));
    checkOutput("edge_bpm_high", 128'(bpm_high), 128'(208));
    checkOutput("edge_final", 128'(final_bpm), 128'(203));

    // Overruns in WAIT_RES (k=5) and in the COMBINE cycle (k=19)
    setEngine(16'd120, 16'd100, 16'd140);
    applyStimulus(vecs[0].fl, vecs[0].fm, vecs[0].fh, 5, 19, 60,
                  lat, err_cnt, err_k, hi_after, wait_after);
    checkOutput("ov_latency", 128'(lat), 128'(20));
    checkOutput("ov_overrun_cnt", 128'(overrun_cnt), 128'(2));
    checkOutput("ov_final", 128'(final_bpm), 128'(120));
    checkOutput("ov_req_flux0", 128'(cap_flux[0]), 128'(vecs[0].fl));
    checkOutput("ov_req_flux1", 128'(cap_flux[1]), 128'(vecs[0].fm));
    checkOutput("ov_req_flux2", 128'(cap_flux[2]), 128'(vecs[0].fh));
    @(negedge clk);
    #2;
    checkOutput("ov_bpm_valid_pulse", 128'(bpm_valid), 128'(0));
    checkOutput("ov_no_new_frame", 128'(busy), 128'(0));

    // Wrong-band result while waiting on band 0
    setEngine(16'd120, 16'd100, 16'd50);
    eng_bad = 1'b1;
    applyStimulus(vecs[1].fl, vecs[1].fm, vecs[1].fh, -1, -1, 60,
                  lat, err_cnt, err_k, hi_after, wait_after);
    eng_bad = 1'b0;
    checkOutput("be_pulse_count", 128'(err_cnt), 128'(1));
    checkOutput("be_pulse_cycle", 128'(err_k), 128'(3));
    checkOutput("be_bpm_high_kept", 128'(hi_after), 128'(140));
    checkOutput("be_still_waiting", 128'(wait_after), 128'(1));
    checkOutput("be_latency", 128'(lat), 128'(20));
    checkOutput("be_bpm_high", 128'(bpm_high), 128'(50));
    checkOutput("be_final", 128'(final_bpm), 128'(97));

    // Asynchronous reset in WAIT_RES of band 1, late result afterwards
    setEngine(16'd55, 16'd66, 16'd77);
    @(negedge clk);
    flux_valid = 1'b1;
    flux_low   = vecs[0].fl;
    flux_mid   = vecs[0].fm;
    flux_high  = vecs[0].fh;
    #2;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      flux_valid = 1'b0;
    end
    #2;
    checkOutput("ar_pre_busy", 128'(busy), 128'(1));
    checkOutput("ar_pre_req_valid", 128'(bus.req_valid), 128'(0));
    checkOutput("ar_pre_bpm_low", 128'(bpm_low), 128'(55));
    reset_n = 1'b0;
    #1;
    checkOutput("ar_busy", 128'(busy), 128'(0));
    checkOutput("ar_req_valid", 128'(bus.req_valid), 128'(0));
    checkOutput("ar_req_band", 128'(bus.req_band), 128'(0));
    checkOutput("ar_req_flux", 128'(bus.req_flux), 128'(0));
    checkOutput("ar_bpm_low", 128'(bpm_low), 128'(0));
    checkOutput("ar_bpm_mid", 128'(bpm_mid), 128'(0));
    checkOutput("ar_bpm_high", 128'(bpm_high), 128'(0));
    checkOutput("ar_final", 128'(final_bpm), 128'(0));
    checkOutput("ar_bpm_valid", 128'(bpm_valid), 128'(0));
    checkOutput("ar_overrun", 128'(overrun_cnt), 128'(0));
    checkOutput("ar_timeout", 128'(timeout_cnt), 128'(0));
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    checkOutput("ar_late_res_no_err", 128'(band_err), 128'(0));
    checkOutput("ar_late_res_idle", 128'(busy), 128'(0));
    @(negedge clk);
    #2;
    checkOutput("ar_late_res_ignored", 128'(bpm_mid), 128'(0));
    setEngine(16'd120, 16'd100, 16'd140);
    applyStimulus(vecs[0].fl, vecs[0].fm, vecs[0].fh, -1, -1, 60,
                  lat, err_cnt, err_k, hi_after, wait_after);
    checkOutput("ar_next_latency", 128'(lat), 128'(20));
    checkOutput("ar_next_bpm_low", 128'(bpm_low), 128'(120));
    checkOutput("ar_next_bpm_mid", 128'(bpm_mid), 128'(100));
    checkOutput("ar_next_bpm_high", 128'(bpm_high), 128'(140));
    checkOutput("ar_next_final", 128'(final_bpm), 128'(120));

    // Overrun counter saturation: silent engine, flux_valid held high
    eng_on = 1'b0;
    for (int k = 0; k < 67500; k++) begin
      @(negedge clk);
      flux_valid = 1'b1;
    end
    @(negedge clk);
    flux_valid = 1'b0;
    lat = -1;
    for (int k = 0; k < 200 && lat < 0; k++) begin
      @(negedge clk);
      #2;
      if (!busy) lat = k;
    end
    checkOutput("sat_returns_idle", 128'(lat >= 0), 128'(1));
    checkOutput("sat_overrun_cnt", 128'(overrun_cnt), 128'(16'hFFFF));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/flux_band_scheduler.md
# flux_band_scheduler

Time-multiplexes one shared autocorrelation engine across the three spectral-flux bands (low/mid/high) instead of instantiating one engine per band. Sits between `spectral_flux` and a single autocorrelation core in the BPM estimator. It captures each per-frame flux triple and issues the bands to the engine in order over a valid/ready handshake. It collects the per-band BPM results, guards against a hung engine with a timeout, and produces the weighted final BPM estimate.

## Interface
- FW, 74, flux word width per band
- BW, 16, BPM word width
- WL, 2, low-band weight
- WM, 1, mid-band weight
- WH, 1, high-band weight
- WSHIFT, 2, log2 of weight sum; elaboration error unless WL+WM+WH == 2**WSHIFT
- TIMEOUT, 65535, max cycles waiting for an engine result
- clk  in  1  system clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- flux_valid  in  1  1-cycle pulse, flux triple valid
- flux_low / flux_mid / flux_high  in  FW  per-band flux for the current frame
- req_valid  out  1  request to engine
- req_ready  in  1  engine accepts request
- req_band  out  2  0=low, 1=mid, 2=high
- req_flux  out  FW  flux for req_band
- res_valid  in  1  1-cycle engine result pulse
- res_band  in  2  band of the result
- res_bpm  in  BW  BPM result
- bpm_low / bpm_mid / bpm_high  out  BW  last accepted per-band BPM
- final_bpm  out  BW  weighted estimate
- bpm_valid  out  1  1-cycle pulse, final_bpm updated
- busy  out  1  high whenever state != IDLE
- overrun_cnt  out  16  frames dropped, saturating
- timeout_cnt  out  16  results timed out, saturating
- band_err  out  1  1-cycle pulse on res_valid with unexpected res_band

## Operation
- FSM states: IDLE, ISSUE, WAIT_RES, COMBINE.
- IDLE: on flux_valid, register all three flux words, set band=0, go to ISSUE.
- ISSUE: req_valid=1, req_band=band, req_flux=held[band]. Hold all three stable until req_ready. On req_valid&&req_ready, clear the wait counter and go to WAIT_RES.
- WAIT_RES: the counter increments each cycle.
  - res_valid && res_band==band: store res_bpm into bpm_<band>.
  - res_valid && res_band!=band: pulse band_err, ignore the result, stay in WAIT_RES.
  - Counter reaches TIMEOUT: increment timeout_cnt and keep the previous bpm_<band>.
  - After a store or a timeout: if band==2, go to COMBINE; otherwise band+1 and go to ISSUE.
- COMBINE: final_bpm <= (WL*bpm_low + WM*bpm_mid + WH*bpm_high) >> WSHIFT. Pulse bpm_valid, then go to IDLE.
- Arithmetic: the sum is computed at BW+WSHIFT+2 bits unsigned, then truncated after the shift. It cannot overflow BW because the weights are normalised.
- Overrun: flux_valid in any state other than IDLE drops that frame (held flux is unchanged) and overrun_cnt += 1, saturating at 0xFFFF.
- Only one request is outstanding at a time. Bands are always issued in order 0,1,2.

## Timing
- Reset values:
  - FSM=IDLE, band=0
  - req_valid=0, req_band=0, req_flux=0
  - bpm_low/mid/high=0, final_bpm=0
  - bpm_valid=0, busy=0, band_err=0
  - overrun_cnt=0, timeout_cnt=0
- flux_valid at cycle t (IDLE) → req_valid=1 at t+1.
- Handshake completes at cycle h → WAIT_RES from h+1.
- Matching res_valid at r → next req_valid at r+1 (bands 0,1). For band 2, COMBINE at r+1, and final_bpm/bpm_valid are visible at r+2.
- Best case (req_ready tied 1, engine latency L): bpm_valid 3·(L+2)+2 cycles after flux_valid.
- A timeout fires in cycle h+TIMEOUT with no res_valid. If res_valid arrives in that same cycle, the result wins and is not counted as a timeout.
- flux_valid in the COMBINE cycle is an overrun.
- reset_n low mid-transaction: immediate return to reset values. A late res_valid after reset is ignored in IDLE.
- res_valid in IDLE/ISSUE/COMBINE is ignored, with no band_err.

## Structure
- Package `bpm_pkg`: `band_t` enum (BAND_LOW, BAND_MID, BAND_HIGH), the FSM state enum, and a `sat_inc16` function.
- One sub-module is natural: `sat_counter` (16-bit saturating incrementer), instantiated twice for overrun_cnt and timeout_cnt.
- No memories; the flux hold registers are 3×FW flops.

## Test plan
- Single frame; engine model with latency 4, req_ready=1, results 120/100/140 → bpm_low/mid/high=120/100/140, final_bpm=(240+100+140)>>2=120, bpm_valid at flux_valid+20.
- req_ready held low for 10 cycles in ISSUE → req_valid, req_band and req_flux stable for all 10 cycles; exactly one request accepted.
- Engine never answers band 1, TIMEOUT=16 → timeout_cnt=1, bpm_mid keeps its prior value (e.g. 100), band 2 still issued, bpm_valid still pulses.
- Second flux_valid while busy → overrun_cnt=1, and the outputs reflect only the first frame. Drive 70000 overruns → overrun_cnt saturates at 0xFFFF.
- res_valid with res_band=2 while waiting on band 0 → band_err pulses once, the state stays WAIT_RES, and bpm_high is unchanged.
- reset_n pulsed low in WAIT_RES of band 1 → all outputs return to reset values asynchronously; the next frame completes normally from band 0.
